// File: rtl/txt_uart_feeder_if.sv
// txt_uart_feeder_if: loader byte stream into the feeder, with backpressure back to the loader.
interface txt_uart_feeder_if;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;
  modport master(output ioctl_download, ioctl_wr, ioctl_data, input ioctl_wait);
  modport slave(input ioctl_download, ioctl_wr, ioctl_data, output ioctl_wait);
endinterface

// File: rtl/txt_uart_feeder.sv
// txt_uart_feeder: buffers loader bytes (LF stripped) and replays them as 8N2 serial,
// pausing LINE_GAP cycles after every CR so the receiving machine can process the line.
module txt_uart_feeder #(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_GAP   = 2500000
) (
  input  logic             clk,
  input  logic             n_reset,
  txt_uart_feeder_if.slave ioctl,
  input  logic             baud_rate,
  output logic             txd,
  output logic             busy,
  output logic             overflow
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam int SLOW = CLK_HZ / 300;
  localparam int CW   = $clog2(2 * SLOW + 1) > 18 ? $clog2(2 * SLOW + 1) : 18;
  localparam int GW   = $clog2(LINE_GAP + 1) > 1 ? $clog2(LINE_GAP + 1) : 1;
  localparam logic [CW-1:0] P_FAST  = CW'(CLK_HZ / 9600);
  localparam logic [CW-1:0] P_SLOW  = CW'(SLOW);
  localparam logic [GW-1:0] GAP_END = GW'(LINE_GAP - 1);
  localparam logic [NW-1:0] FULL    = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] HIGH    = NW'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t        r_state, w_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [NW-1:0] r_count;
  logic          r_wait, r_ovf, r_dl, r_txd, w_txd, r_cr, w_cr;
  logic [CW-1:0] r_cnt, w_cnt, r_period, w_period;
  logic [GW-1:0] r_gap, w_gap;
  logic [7:0]    r_sh, w_sh;
  logic [2:0]    r_bit, w_bit;
  logic          w_strobe, w_pop, w_push;

  assign w_strobe         = ioctl.ioctl_download && ioctl.ioctl_wr && ioctl.ioctl_data != 8'h0A;
  assign w_pop            = r_state == IDLE && r_count != '0;
  // a full FIFO still takes the byte when the transmitter pops in the same cycle
  assign w_push           = w_strobe && (r_count != FULL || w_pop);
  assign ioctl.ioctl_wait = r_wait;
  assign txd              = r_txd;
  assign busy             = r_count != '0 || r_state != IDLE;
  assign overflow         = r_ovf;

  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= ioctl.ioctl_data;

  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_wait  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dl    <= 1'b0;
    end else begin
      r_wp    <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp    <= w_pop ? r_rp + AW'(1) : r_rp;
      r_count <= r_count + NW'(w_push) - NW'(w_pop);
      r_wait  <= r_count >= HIGH;
      r_dl    <= ioctl.ioctl_download;
      r_ovf   <= (ioctl.ioctl_download && !r_dl) ? 1'b0 : r_ovf || (w_strobe && !w_push);
    end

  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_state  <= IDLE;
      r_txd    <= 1'b1;
      r_cnt    <= '0;
      r_period <= '0;
      r_gap    <= '0;
      r_sh     <= '0;
      r_bit    <= '0;
      r_cr     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_txd    <= w_txd;
      r_cnt    <= w_cnt;
      r_period <= w_period;
      r_gap    <= w_gap;
      r_sh     <= w_sh;
      r_bit    <= w_bit;
      r_cr     <= w_cr;
    end

  // w_txd is the line level for the next cycle, so txd leaves a flop with no decode glitches
  always_comb begin
    w_state  = r_state;
    w_txd    = 1'b1;
    w_cnt    = r_cnt + CW'(1);
    w_period = r_period;
    w_gap    = '0;
    w_sh     = r_sh;
    w_bit    = r_bit;
    w_cr     = r_cr;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (w_pop) begin
          w_state  = START;
          w_txd    = 1'b0;
          w_sh     = r_mem[r_rp];
          w_cr     = r_mem[r_rp] == 8'h0D;
          w_period = baud_rate ? P_SLOW : P_FAST;
        end
      end
      START: begin
        w_txd = 1'b0;
        if (r_cnt == r_period - CW'(1)) begin
          w_state = DATA;
          w_cnt   = '0;
          w_bit   = '0;
          w_txd   = r_sh[0];
        end
      end
      DATA: begin
        w_txd = r_sh[0];
        if (r_cnt == r_period - CW'(1)) begin
          w_cnt   = '0;
          w_state = r_bit == 3'd7 ? STOP : DATA;
          w_bit   = r_bit + 3'd1;
          w_sh    = r_sh >> 1;
          w_txd   = r_bit == 3'd7 ? 1'b1 : r_sh[1];
        end
      end
      STOP:
        if (r_cnt == {r_period[CW-2:0], 1'b0} - CW'(1)) begin
          w_cnt   = '0;
          w_state = r_cr ? GAP : IDLE;
        end
      GAP: begin
        w_cnt   = '0;
        w_gap   = r_gap == GAP_END ? '0 : r_gap + GW'(1);
        w_state = r_gap == GAP_END ? IDLE : GAP;
      end
      default: w_state = IDLE;
    endcase
  end
endmodule
